sudoku_board_dp: RTL and testbench
==================================

# sudoku_board_dp

Parametrised Sudoku board datapath: the successor to the fixed 4x4 `dp_module`, generalised to any `BOX`x`BOX` box size (4x4, 9x9, ...). It holds the board and a per-cell "given" mask, accepts puzzle loads and user moves through a ready/ack handshake, and clears user entries on try-again. A multi-cycle scan FSM checks every row, column and box for duplicates and reports solved/conflict. It sits between the game-control FSM and the display/readout logic.

## Interface
Parameters:
- `BOX`, 2, box edge; board edge `N = BOX*BOX`, `CELLS = N*N`
- `VW`, `$clog2(N+1)`, cell value width; 0 = empty, legal values 1..N (3 for BOX=2)
- `IW`, `$clog2(CELLS)`, cell index width; index = row*N + col

Ports:
- `clka`  in  1  single clock; all state changes on its rising edge
- `restart`  in  1  reset, synchronous, active-high
- `load_valid`  in  1  write a puzzle cell (IDLE only)
- `load_idx`  in  IW  cell to load
- `load_val`  in  VW  value; nonzero marks the cell given
- `inp_valid`  in  1  user move request
- `inp_ready`  out  1  move accepted this cycle if `inp_valid`
- `inp_idx`  in  IW  target cell
- `inp_val`  in  VW  value; 0 clears the cell
- `inp_ack`  out  1  one-cycle pulse: move written
- `inp_err`  out  1  one-cycle pulse: move rejected
- `clear_user`  in  1  try-again: clear all non-given cells
- `check_req`  in  1  start a scan (IDLE only)
- `busy`  out  1  scan in progress (SCAN or DONE)
- `done`  out  1  one-cycle pulse: results valid
- `solved`  out  1  last scan: board full and conflict-free
- `conflict`  out  1  last scan found a duplicate
- `conflict_idx`  out  IW  cell where the first duplicate was detected
- `rd_idx`  in  IW  readout address
- `rd_val`  out  VW  value at `rd_idx`, registered
- `rd_given`  out  1  given flag at `rd_idx`, registered
- `fill_flag`  out  CELLS  bit i = cell i nonzero
- `full`  out  1  all cells nonzero

## Operation
- States: IDLE, SCAN, DONE.
  - IDLE + `check_req` -> SCAN.
  - SCAN -> DONE after the last element, or on the first conflict.
  - DONE -> IDLE unconditionally.
- Write priority in IDLE: `restart` > `clear_user` > `load_valid` > `inp_valid`.
- `inp_ready = (state==IDLE) & !clear_user & !load_valid`.
- Move handshake: a move is accepted when `inp_valid & inp_ready`.
  - `inp_err` if the cell is given, `inp_val > N`, or `inp_idx >= CELLS`; cell unchanged.
  - Otherwise the cell is written and `inp_ack` pulses.
  - No ack or err pulse is raised when `inp_valid` is dropped for lack of ready.
- Load: ignored if `load_idx >= CELLS` or `load_val > N`. Otherwise writes the value and sets `given = (load_val != 0)`.
- `clear_user`: in one cycle, zero every cell whose given bit is 0. Givens are untouched. Honoured in IDLE only.
- Scan order: 3N groups × N positions, one cell per cycle.
  - Groups 0..N-1 are rows: idx = g*N + p.
  - Groups N..2N-1 are columns, c = g-N: idx = p*N + c.
  - Groups 2N..3N-1 are boxes, b = g-2N: idx = ((b/BOX)*BOX + p/BOX)*N + (b%BOX)*BOX + p%BOX.
- Per group, an N-bit seen mask is cleared at p = 0.
  - A nonzero value v with seen[v-1] already set is a conflict: latch `conflict_idx` = idx and go to DONE.
  - Otherwise set seen[v-1].
- In DONE: `solved = !conflict & full`. `solved`, `conflict` and `conflict_idx` hold until the next accepted `check_req` clears them.

## Timing
- Reset: board, given mask and state all go to 0 / IDLE. Every output is 0 except `inp_ready`, which is 1.
- Move or load at edge t: `inp_ack`/`inp_err` high in cycle t+1. `fill_flag`, `full` and readout reflect the write from t+1.
- Read latency: `rd_val`/`rd_given` show cycle-t `rd_idx` in cycle t+1.
- Scan with `check_req` sampled at edge 0:
  - SCAN occupies cycles 1..3N², examining element k in cycle k.
  - A clean scan has `done` in cycle 3N²+1 (49 for BOX=2).
  - A conflict at element k gives `done` in cycle k+1.
- `check_req` and an accepted move in the same IDLE cycle: both are taken, and the scan sees the new value.
- `check_req` while busy is ignored.
- `restart` mid-scan: IDLE next cycle, no `done` pulse, results cleared.

## Structure
- Package `sudoku_pkg`:
  - state enum;
  - functions `n_of(BOX)` and `cell_idx(BOX, g, p)` implementing the mapping above.
- Sub-module `sudoku_cell_index`: combinational group/position -> cell index, shared by the scan and the testbench model.

## Test plan
- Reset: assert `restart` 2 cycles -> all `fill_flag` 0, `busy` 0, `inp_ready` 1, `rd_val` 0 for every idx.
- Solved 4x4: load rows 1234/3412/2143/4321 and pulse `check_req` at cycle 0 -> `busy` cycles 1..49, `done` at 49, `solved` 1, `conflict` 0.
- Row conflict: load idx0=1, idx3=1, then check -> `done` at cycle 5, `conflict` 1, `conflict_idx` 3, `solved` 0.
- Handshake: move to given idx0 -> `inp_err`; `inp_val`=5 -> `inp_err`; idx5 value 2 -> `inp_ack`, `fill_flag[5]` 1; move during scan -> `inp_ready` 0, no pulse.
- Try-again: givens idx0,1 plus user writes idx2,7, then `clear_user` -> next cycle `fill_flag` = 16'h0003, givens intact.
- Restart mid-scan at cycle 20 of a solved-board check -> IDLE at 21, no `done`, `solved` 0; repeat the solved-board case at BOX=3 -> `done` at cycle 244.

Source files
------------

// File: rtl/sudoku_pkg.sv
// sudoku_pkg
// Shared types and helpers for the parametrised Sudoku board datapath.
//   scan_state_e : IDLE / SCAN / DONE states of the duplicate-scan FSM
//   n_of()       : board edge for a given box edge
//   cell_idx()   : maps (group, position) of the scan onto a cell index,
//                  where groups 0..N-1 are rows, N..2N-1 columns and
//                  2N..3N-1 boxes
package sudoku_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } scan_state_e;

    function automatic int n_of(input int box);
        return box * box;
    endfunction

    function automatic int cell_idx(input int box, input int g, input int p);
        int n;
        int b;
        n = n_of(box);
        b = g - 2 * n;
        if (g < n) begin
            return g * n + p;
        end else if (g < 2 * n) begin
            return p * n + (g - n);
        end
        // Box b: its top-left corner is at row (b/BOX)*BOX, col (b%BOX)*BOX;
        // position p walks the box row-major.
        return ((b / box) * box + p / box) * n + (b % box) * box + p % box;
    endfunction

endpackage

// File: rtl/sudoku_cell_index.sv
// sudoku_cell_index
// Combinational translation of a scan (group, position) pair into the
// row-major cell index it refers to.
//   grp : scan group, 0..3N-1 (rows, then columns, then boxes)
//   pos : position inside the group, 0..N-1
//   idx : cell index row*N + col
module sudoku_cell_index
    import sudoku_pkg::*;
#(
    parameter int BOX = 2,
    parameter int IW  = 4,
    parameter int GW  = 4,
    parameter int PW  = 2
) (
    input  logic [GW-1:0] grp,
    input  logic [PW-1:0] pos,
    output logic [IW-1:0] idx
);

    // The mapping lives in the package so that every user agrees on the
    // same traversal; here it is just evaluated on the live counters.
    always_comb begin
        idx = IW'(cell_idx(BOX, int'(grp), int'(pos)));
    end

endmodule

// File: rtl/sudoku_board_dp.sv
// sudoku_board_dp
// Board storage plus given mask for a BOX x BOX Sudoku, with puzzle loads,
// user moves (ready/ack handshake), try-again clearing and a one-cell-per-
// cycle duplicate scan over every row, column and box.
//   clka / restart        : clock and synchronous active-high reset
//   load_*                : puzzle cell write, marks nonzero cells as given
//   inp_*                 : user move request, ready, ack / err pulses
//   clear_user            : wipe every non-given cell in one cycle
//   check_req             : start a scan; busy / done / solved / conflict
//                           and conflict_idx report its outcome
//   rd_idx/rd_val/rd_given: registered readout port
//   fill_flag / full      : per-cell and whole-board occupancy
module sudoku_board_dp
    import sudoku_pkg::*;
#(
    parameter int BOX = 2,
    parameter int VW  = $clog2(BOX * BOX + 1),
    parameter int IW  = $clog2(BOX * BOX * BOX * BOX)
) (
    input  logic                              clka,
    input  logic                              restart,
    input  logic                              load_valid,
    input  logic [IW-1:0]                     load_idx,
    input  logic [VW-1:0]                     load_val,
    input  logic                              inp_valid,
    output logic                              inp_ready,
    input  logic [IW-1:0]                     inp_idx,
    input  logic [VW-1:0]                     inp_val,
    output logic                              inp_ack,
    output logic                              inp_err,
    input  logic                              clear_user,
    input  logic                              check_req,
    output logic                              busy,
    output logic                              done,
    output logic                              solved,
    output logic                              conflict,
    output logic [IW-1:0]                     conflict_idx,
    input  logic [IW-1:0]                     rd_idx,
    output logic [VW-1:0]                     rd_val,
    output logic                              rd_given,
    output logic [BOX*BOX*BOX*BOX-1:0]        fill_flag,
    output logic                              full
);

    localparam int N      = n_of(BOX);
    localparam int CELLS  = N * N;
    localparam int GROUPS = 3 * N;
    localparam int GW     = $clog2(GROUPS);
    localparam int PW     = $clog2(N);

    // Index comparisons are done one bit wider so that CELLS itself is
    // representable when it is an exact power of two.
    localparam logic [IW:0]   CELLS_W  = (IW + 1)'(CELLS);
    localparam logic [VW-1:0] MAX_VAL  = VW'(N);
    localparam logic [GW-1:0] LAST_GRP = GW'(GROUPS - 1);
    localparam logic [PW-1:0] LAST_POS = PW'(N - 1);
    localparam logic [N-1:0]  ONE_N    = N'(1);

    scan_state_e       state_q, state_d;
    logic [VW-1:0]     board_q [CELLS];
    logic [VW-1:0]     board_d [CELLS];
    logic [CELLS-1:0]  given_q, given_d;
    logic [GW-1:0]     grp_q, grp_d;
    logic [PW-1:0]     pos_q, pos_d;
    logic [N-1:0]      seen_q, seen_d;
    logic              inp_ack_q, inp_ack_d;
    logic              inp_err_q, inp_err_d;
    logic              done_q, done_d;
    logic              solved_q, solved_d;
    logic              conflict_q, conflict_d;
    logic [IW-1:0]     conflict_idx_q, conflict_idx_d;
    logic [VW-1:0]     rd_val_q, rd_val_d;
    logic              rd_given_q, rd_given_d;

    logic [IW-1:0]     scan_idx;
    logic [VW-1:0]     scan_val;
    logic [N-1:0]      scan_bit;
    logic [N-1:0]      seen_base;
    logic              scan_dup;
    logic              scan_last;
    logic              load_ok;
    logic              inp_ok;
    logic              rd_in_range;

    sudoku_cell_index #(
        .BOX (BOX),
        .IW  (IW),
        .GW  (GW),
        .PW  (PW)
    ) u_cell_index (
        .grp (grp_q),
        .pos (pos_q),
        .idx (scan_idx)
    );

    // Occupancy view of the board; the board only changes in IDLE so this
    // is stable for the whole scan and can feed the solved decision.
    always_comb begin
        fill_flag = '0;
        for (int i = 0; i < CELLS; i++) begin
            fill_flag[i] = (board_q[i] != '0);
        end
        full = &fill_flag;
    end

    // Scan element decode: the seen mask restarts at the first position of
    // each group, and a nonzero value whose bit is already set is a
    // duplicate within that row, column or box.
    always_comb begin
        scan_val  = board_q[scan_idx];
        scan_bit  = ONE_N << (scan_val - VW'(1));
        seen_base = (pos_q == '0) ? '0 : seen_q;
        scan_dup  = (scan_val != '0) && ((seen_base & scan_bit) != '0);
        scan_last = (grp_q == LAST_GRP) && (pos_q == LAST_POS);
    end

    // Request qualification: out-of-range cells and values above N are
    // never written; a move to a given cell is refused as well.
    always_comb begin
        load_ok     = ({1'b0, load_idx} < CELLS_W) && (load_val <= MAX_VAL);
        inp_ok      = ({1'b0, inp_idx} < CELLS_W) && (inp_val <= MAX_VAL)
                      && !given_q[inp_idx];
        inp_ready   = (state_q == ST_IDLE) && !clear_user && !load_valid;
        rd_in_range = ({1'b0, rd_idx} < CELLS_W);
    end

    // Next-state logic for the board and the scan FSM. In IDLE the board
    // writers are prioritised clear_user > load > move, and a check request
    // may be taken in the same cycle as a move so the scan sees it.
    always_comb begin
        state_d        = state_q;
        board_d        = board_q;
        given_d        = given_q;
        grp_d          = grp_q;
        pos_d          = pos_q;
        seen_d         = seen_q;
        inp_ack_d      = 1'b0;
        inp_err_d      = 1'b0;
        done_d         = 1'b0;
        solved_d       = solved_q;
        conflict_d     = conflict_q;
        conflict_idx_d = conflict_idx_q;

        case (state_q)
            ST_IDLE: begin
                if (clear_user) begin
                    for (int i = 0; i < CELLS; i++) begin
                        if (!given_q[i]) begin
                            board_d[i] = '0;
                        end
                    end
                end else if (load_valid) begin
                    if (load_ok) begin
                        board_d[load_idx] = load_val;
                        given_d[load_idx] = (load_val != '0);
                    end
                end else if (inp_valid) begin
                    if (inp_ok) begin
                        board_d[inp_idx] = inp_val;
                        inp_ack_d        = 1'b1;
                    end else begin
                        inp_err_d = 1'b1;
                    end
                end

                if (check_req) begin
                    state_d        = ST_SCAN;
                    grp_d          = '0;
                    pos_d          = '0;
                    seen_d         = '0;
                    solved_d       = 1'b0;
                    conflict_d     = 1'b0;
                    conflict_idx_d = '0;
                end
            end

            ST_SCAN: begin
                if (scan_dup) begin
                    state_d        = ST_DONE;
                    done_d         = 1'b1;
                    conflict_d     = 1'b1;
                    conflict_idx_d = scan_idx;
                    solved_d       = 1'b0;
                end else begin
                    seen_d = seen_base | ((scan_val != '0) ? scan_bit : '0);
                    if (scan_last) begin
                        state_d  = ST_DONE;
                        done_d   = 1'b1;
                        solved_d = full;
                    end else if (pos_q == LAST_POS) begin
                        pos_d = '0;
                        grp_d = grp_q + GW'(1);
                    end else begin
                        pos_d = pos_q + PW'(1);
                    end
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Readout is taken from the next-state board so a write and a read of
    // the same cell in one cycle return the freshly written value.
    always_comb begin
        rd_val_d   = rd_in_range ? board_d[rd_idx] : '0;
        rd_given_d = rd_in_range ? given_d[rd_idx] : 1'b0;
    end

    // All state is registered here; restart wipes board, givens, results
    // and returns the FSM to IDLE, abandoning any scan without a done pulse.
    always_ff @(posedge clka) begin
        if (restart) begin
            state_q        <= ST_IDLE;
            for (int i = 0; i < CELLS; i++) begin
                board_q[i] <= '0;
            end
            given_q        <= '0;
            grp_q          <= '0;
            pos_q          <= '0;
            seen_q         <= '0;
            inp_ack_q      <= 1'b0;
            inp_err_q      <= 1'b0;
            done_q         <= 1'b0;
            solved_q       <= 1'b0;
            conflict_q     <= 1'b0;
            conflict_idx_q <= '0;
            rd_val_q       <= '0;
            rd_given_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            board_q        <= board_d;
            given_q        <= given_d;
            grp_q          <= grp_d;
            pos_q          <= pos_d;
            seen_q         <= seen_d;
            inp_ack_q      <= inp_ack_d;
            inp_err_q      <= inp_err_d;
            done_q         <= done_d;
            solved_q       <= solved_d;
            conflict_q     <= conflict_d;
            conflict_idx_q <= conflict_idx_d;
            rd_val_q       <= rd_val_d;
            rd_given_q     <= rd_given_d;
        end
    end

    assign busy         = (state_q == ST_SCAN) || (state_q == ST_DONE);
    assign inp_ack      = inp_ack_q;
    assign inp_err      = inp_err_q;
    assign done         = done_q;
    assign solved       = solved_q;
    assign conflict     = conflict_q;
    assign conflict_idx = conflict_idx_q;
    assign rd_val       = rd_val_q;
    assign rd_given     = rd_given_q;

endmodule

// File: tb/tb_sudoku_board_dp.sv
// tb_sudoku_board_dp
// Scoreboard bench for sudoku_board_dp: expected move pulses and scan
// results are queued when stimulus is driven and compared when the DUT
// raises inp_ack/inp_err or done. A BOX=2 instance covers the main
// behaviour, a BOX=3 instance the larger solved-board scan.
module tb_sudoku_board_dp;

    localparam int N2  = 4;
    localparam int C2  = 16;
    localparam int IW2 = 4;
    localparam int VW2 = 3;
    localparam int N3  = 9;
    localparam int C3  = 81;
    localparam int IW3 = 7;
    localparam int VW3 = 4;

    typedef struct {
        int   cyc;
        logic solved;
        logic conflict;
        int   cidx;
    } scan_exp_t;

    logic clka = 1'b0;
    always #5 clka = ~clka;

    // BOX=2 instance signals
    logic           restart = 1'b1;
    logic           loadValid = 1'b0;
    logic [IW2-1:0] loadIdx = '0;
    logic [VW2-1:0] loadVal = '0;
    logic           inpValid = 1'b0;
    logic           inpReady;
    logic [IW2-1:0] inpIdx = '0;
    logic [VW2-1:0] inpVal = '0;
    logic           inpAck, inpErr;
    logic           clearUser = 1'b0;
    logic           checkReq = 1'b0;
    logic           busy, done, solved, conflict;
    logic [IW2-1:0] conflictIdx;
    logic [IW2-1:0] rdIdx = '0;
    logic [VW2-1:0] rdVal;
    logic           rdGiven;
    logic [C2-1:0]  fillFlag;
    logic           full;

    // BOX=3 instance signals
    logic           restart3 = 1'b1;
    logic           loadValid3 = 1'b0;
    logic [IW3-1:0] loadIdx3 = '0;
    logic [VW3-1:0] loadVal3 = '0;
    logic           inpReady3;
    logic           inpAck3, inpErr3;
    logic           checkReq3 = 1'b0;
    logic           busy3, done3, solved3, conflict3;
    logic [IW3-1:0] conflictIdx3;
    logic [VW3-1:0] rdVal3;
    logic           rdGiven3;
    logic [C3-1:0]  fillFlag3;
    logic           full3;

    int checkCount = 0;
    int errorCount = 0;
    int edgeCnt = 0;

    logic [1:0]  moveQ[$];
    scan_exp_t   scanQ[$];
    scan_exp_t   scanQ3[$];

    logic [VW2-1:0] boardM [C2];
    logic           givenM [C2];

    sudoku_board_dp #(.BOX(2)) dut (
        .clka         (clka),
        .restart      (restart),
        .load_valid   (loadValid),
        .load_idx     (loadIdx),
        .load_val     (loadVal),
        .inp_valid    (inpValid),
        .inp_ready    (inpReady),
        .inp_idx      (inpIdx),
        .inp_val      (inpVal),
        .inp_ack      (inpAck),
        .inp_err      (inpErr),
        .clear_user   (clearUser),
        .check_req    (checkReq),
        .busy         (busy),
        .done         (done),
        .solved       (solved),
        .conflict     (conflict),
        .conflict_idx (conflictIdx),
        .rd_idx       (rdIdx),
        .rd_val       (rdVal),
        .rd_given     (rdGiven),
        .fill_flag    (fillFlag),
        .full         (full)
    );

    sudoku_board_dp #(.BOX(3)) dut3 (
        .clka         (clka),
        .restart      (restart3),
        .load_valid   (loadValid3),
        .load_idx     (loadIdx3),
        .load_val     (loadVal3),
        .inp_valid    (1'b0),
        .inp_ready    (inpReady3),
        .inp_idx      ('0),
        .inp_val      ('0),
        .inp_ack      (inpAck3),
        .inp_err      (inpErr3),
        .clear_user   (1'b0),
        .check_req    (checkReq3),
        .busy         (busy3),
        .done         (done3),
        .solved       (solved3),
        .conflict     (conflict3),
        .conflict_idx (conflictIdx3),
        .rd_idx       ('0),
        .rd_val       (rdVal3),
        .rd_given     (rdGiven3),
        .fill_flag    (fillFlag3),
        .full         (full3)
    );

    always @(posedge clka) edgeCnt <= edgeCnt + 1;

    task automatic checkOutput(input string tag, input logic [63:0] actual,
                               input logic [63:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)",
                     tag, actual, expected, $time);
        end
    endtask

    task automatic stepCycle();
        @(negedge clka);
    endtask

    function automatic logic [C2-1:0] fillModel();
        logic [C2-1:0] f;
        for (int i = 0; i < C2; i++) f[i] = (boardM[i] != '0);
        return f;
    endfunction

    task automatic clearModel();
        for (int i = 0; i < C2; i++) begin
            boardM[i] = '0;
            givenM[i] = 1'b0;
        end
    endtask

    task automatic doRestart();
        restart = 1'b1;
        stepCycle();
        stepCycle();
        restart = 1'b0;
        clearModel();
    endtask

    task automatic loadCell(input int idx, input int val);
        loadValid = 1'b1;
        loadIdx   = IW2'(idx);
        loadVal   = VW2'(val);
        stepCycle();
        loadValid = 1'b0;
        if (idx < C2 && val <= N2) begin
            boardM[idx] = VW2'(val);
            givenM[idx] = (val != 0);
        end
    endtask

    // Drive one user move, predict ack or err from the bench's own board
    // model, and queue that prediction for the pulse monitor.
    task automatic applyStimulus(input int idx, input int val);
        logic err;
        err = (idx >= C2) || (val > N2) || givenM[idx % C2];
        inpValid = 1'b1;
        inpIdx   = IW2'(idx);
        inpVal   = VW2'(val);
        #1;
        checkOutput("inpReadyIdle", inpReady, 1);
        moveQ.push_back({~err, err});
        stepCycle();
        inpValid = 1'b0;
        if (!err) boardM[idx] = VW2'(val);
    endtask

    task automatic startCheck(input int offset, input logic expSolved,
                              input logic expConflict, input int expIdx);
        scan_exp_t e;
        e.cyc      = edgeCnt + offset;
        e.solved   = expSolved;
        e.conflict = expConflict;
        e.cidx     = expIdx;
        scanQ.push_back(e);
        checkReq = 1'b1;
        stepCycle();
        checkReq = 1'b0;
    endtask

    task automatic waitScan(input int bound);
        for (int i = 0; i < bound && scanQ.size() != 0; i++) stepCycle();
        stepCycle();
        checkOutput("scanDrained", scanQ.size(), 0);
    endtask

    // Pulse monitor for the BOX=2 instance.
    always @(negedge clka) begin
        if (inpAck === 1'b1 || inpErr === 1'b1) begin
            if (moveQ.size() == 0) begin
                checkOutput("unexpectedMovePulse", {inpAck, inpErr}, 2'b00);
            end else begin
                checkOutput("movePulse", {inpAck, inpErr}, moveQ.pop_front());
            end
        end
        if (done === 1'b1) begin
            if (scanQ.size() == 0) begin
                checkOutput("unexpectedDone", done, 0);
            end else begin
                scan_exp_t e;
                e = scanQ.pop_front();
                checkOutput("doneCycle", edgeCnt, e.cyc);
                checkOutput("busyAtDone", busy, 1);
                checkOutput("solved", solved, e.solved);
                checkOutput("conflict", conflict, e.conflict);
                checkOutput("conflictIdx", conflictIdx, e.cidx);
            end
        end
    end

    // Done monitor for the BOX=3 instance.
    always @(negedge clka) begin
        if (done3 === 1'b1) begin
            if (scanQ3.size() == 0) begin
                checkOutput("unexpectedDone3", done3, 0);
            end else begin
                scan_exp_t e;
                e = scanQ3.pop_front();
                checkOutput("doneCycle3", edgeCnt, e.cyc);
                checkOutput("solved3", solved3, e.solved);
                checkOutput("conflict3", conflict3, e.conflict);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int m;
        int sol [16];
        sol = '{1,2,3,4, 3,4,1,2, 2,1,4,3, 4,3,2,1};
        clearModel();
        stepCycle();

        // ---- Reset state ----
        $display("[TB] reset checks");
        doRestart();
        checkOutput("rstFill", fillFlag, 0);
        checkOutput("rstBusy", busy, 0);
        checkOutput("rstReady", inpReady, 1);
        checkOutput("rstDone", done, 0);
        checkOutput("rstSolved", solved, 0);
        checkOutput("rstConflict", conflict, 0);
        checkOutput("rstFull", full, 0);
        checkOutput("rstAckErr", {inpAck, inpErr}, 0);
        for (int i = 0; i < C2; i++) begin
            rdIdx = IW2'(i);
            stepCycle();
            checkOutput("rstRdVal", rdVal, 0);
        end

        // ---- Solved 4x4 board ----
        $display("[TB] solved board scan");
        for (int i = 0; i < C2; i++) loadCell(i, sol[i]);
        checkOutput("fullAfterLoad", full, 1);
        checkOutput("fillAfterLoad", fillFlag, fillModel());
        rdIdx = IW2'(6);
        stepCycle();
        checkOutput("rdVal6", rdVal, 1);
        checkOutput("rdGiven6", rdGiven, 1);
        startCheck(49, 1'b1, 1'b0, 0);
        checkOutput("busyCycle1", busy, 1);
        checkOutput("readyDuringScan", inpReady, 0);
        waitScan(200);
        checkOutput("busyAfterScan", busy, 0);
        checkOutput("solvedHold", solved, 1);

        // ---- Restart in the middle of a scan ----
        $display("[TB] restart mid-scan");
        m = edgeCnt;
        checkReq = 1'b1;
        stepCycle();
        checkReq = 1'b0;
        checkOutput("solvedClearedByCheck", solved, 0);
        while (edgeCnt < m + 20) stepCycle();
        checkOutput("busyCycle20", busy, 1);
        restart = 1'b1;
        stepCycle();
        restart = 1'b0;
        clearModel();
        checkOutput("idleAfterRestart", busy, 0);
        checkOutput("solvedAfterRestart", solved, 0);
        checkOutput("fillAfterRestart", fillFlag, 0);
        for (int i = 0; i < 40; i++) stepCycle();

        // ---- Row conflict ----
        $display("[TB] row conflict");
        loadCell(0, 1);
        loadCell(3, 1);
        startCheck(5, 1'b0, 1'b1, 3);
        waitScan(100);

        // ---- Handshake ----
        $display("[TB] handshake");
        applyStimulus(0, 2);
        applyStimulus(5, 5);
        applyStimulus(5, 2);
        stepCycle();
        checkOutput("fill5", fillFlag[5], 1);
        checkOutput("fillHandshake", fillFlag, fillModel());
        loadCell(4, 5);
        checkOutput("loadBadValIgnored", fillFlag, fillModel());

        // Move and check in one cycle: scan must see idx1=1 duplicating idx0.
        m = edgeCnt;
        inpValid = 1'b1;
        inpIdx   = IW2'(1);
        inpVal   = VW2'(1);
        checkReq = 1'b1;
        #1;
        checkOutput("readyWithCheck", inpReady, 1);
        moveQ.push_back(2'b10);
        begin
            scan_exp_t e;
            e.cyc = m + 3; e.solved = 1'b0; e.conflict = 1'b1; e.cidx = 1;
            scanQ.push_back(e);
        end
        stepCycle();
        checkReq = 1'b0;
        boardM[1] = VW2'(1);
        inpIdx   = IW2'(6);
        inpVal   = VW2'(3);
        #1;
        checkOutput("readyWhileBusy", inpReady, 0);
        stepCycle();
        stepCycle();
        inpValid = 1'b0;
        waitScan(100);
        rdIdx = IW2'(6);
        stepCycle();
        checkOutput("noWriteWhileBusy", rdVal, 0);

        // ---- Try again ----
        $display("[TB] try-again");
        doRestart();
        loadCell(0, 1);
        loadCell(1, 2);
        applyStimulus(2, 3);
        applyStimulus(7, 4);
        stepCycle();
        checkOutput("fillBeforeClear", fillFlag, fillModel());
        clearUser = 1'b1;
        inpValid  = 1'b1;
        inpIdx    = IW2'(9);
        inpVal    = VW2'(1);
        #1;
        checkOutput("readyDuringClear", inpReady, 0);
        stepCycle();
        clearUser = 1'b0;
        inpValid  = 1'b0;
        boardM[2] = '0;
        boardM[7] = '0;
        checkOutput("fillAfterClear", fillFlag, 16'h0003);
        rdIdx = IW2'(1);
        stepCycle();
        checkOutput("rdVal1", rdVal, 2);
        checkOutput("rdGiven1", rdGiven, 1);
        rdIdx = IW2'(2);
        stepCycle();
        checkOutput("rdVal2", rdVal, 0);
        checkOutput("rdGiven2", rdGiven, 0);

        // ---- Solved 9x9 board ----
        $display("[TB] BOX=3 solved board");
        restart3 = 1'b1;
        stepCycle();
        stepCycle();
        restart3 = 1'b0;
        checkOutput("rstFill3", fillFlag3, 0);
        for (int r = 0; r < N3; r++) begin
            for (int c = 0; c < N3; c++) begin
                loadValid3 = 1'b1;
                loadIdx3   = IW3'(r * N3 + c);
                loadVal3   = VW3'(((r * 3 + r / 3 + c) % 9) + 1);
                stepCycle();
            end
        end
        loadValid3 = 1'b0;
        checkOutput("full3", full3, 1);
        begin
            scan_exp_t e;
            e.cyc = edgeCnt + 244; e.solved = 1'b1; e.conflict = 1'b0; e.cidx = 0;
            scanQ3.push_back(e);
        end
        checkReq3 = 1'b1;
        stepCycle();
        checkReq3 = 1'b0;
        checkOutput("busy3", busy3, 1);
        for (int i = 0; i < 400 && scanQ3.size() != 0; i++) stepCycle();
        stepCycle();
        checkOutput("scanDrained3", scanQ3.size(), 0);

        checkOutput("moveQEmpty", moveQ.size(), 0);
        checkOutput("scanQEmpty", scanQ.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
